// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the hardware-loop sequencer.
package cv32e40p_pkg;

   localparam int HWLP_N_REGS = 2;

   typedef enum logic [0:0] {
      HWLP_IDLE,
      HWLP_JUMP_PEND
   } hwlp_seq_state_e;

endpackage

// File: rtl/cv32e40p_hwloop_match.sv
// Per-loop end-of-body detector: flags the last body instruction in ID and
// whether that pass must branch back (more than one iteration remaining).
module cv32e40p_hwloop_match (
   input  logic [31:0] end_addr_i,
   input  logic [31:0] counter_i,
   input  logic [31:0] pc_i,
   output logic        match_o,
   output logic        take_o,
   output logic        active_o
);

   // end address points past the last instruction; modulo wrap is intended
   assign active_o = (counter_i != 32'd0);
   assign match_o  = (pc_i == (end_addr_i - 32'd4)) && active_o;
   assign take_o   = match_o && (counter_i >= 32'd2);

endmodule

// File: rtl/cv32e40p_hwloop_sequencer.sv
// Hardware-loop consumer: selects the innermost matching loop, strobes its
// decrement back to the register file and requests a jump to the loop start
// from the prefetcher through a valid/ready handshake.
//
//   state          | meaning
//   HWLP_IDLE      | evaluating ID PC against loop end addresses
//   HWLP_JUMP_PEND | jump to loop start requested, waiting for ready/flush
module cv32e40p_hwloop_sequencer
   import cv32e40p_pkg::*;
#(
   parameter int N_REGS     = HWLP_N_REGS,
   parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       hwlp_start_addr_i [N_REGS],
   input  logic [31:0]       hwlp_end_addr_i   [N_REGS],
   input  logic [31:0]       hwlp_counter_i    [N_REGS],
   input  logic [31:0]       id_pc_i,
   input  logic              id_advance_i,
   input  logic              flush_i,
   output logic [N_REGS-1:0] hwlp_dec_cnt_o,
   output logic              hwlp_jump_o,
   output logic [31:0]       hwlp_target_o,
   input  logic              hwlp_jump_ready_i,
   output logic [N_REGS-1:0] hwlp_active_o
);

   hwlp_seq_state_e         state;
   logic [N_REGS-1:0]       match;
   logic [N_REGS-1:0]       take;
   logic                    any_match;
   logic [N_REG_BITS-1:0]   sel_idx;
   logic                    sel_take;

   for (genvar k = 0; k < N_REGS; k++) begin : g_match
      cv32e40p_hwloop_match u_match (
         .end_addr_i (hwlp_end_addr_i[k]),
         .counter_i  (hwlp_counter_i[k]),
         .pc_i       (id_pc_i),
         .match_o    (match[k]),
         .take_o     (take[k]),
         .active_o   (hwlp_active_o[k])
      );
   end

   // lowest index wins so the innermost loop is always serviced first
   always_comb begin
      any_match = 1'b0;
      sel_idx   = '0;
      for (int k = N_REGS - 1; k >= 0; k--) begin
         if (match[k]) begin
            any_match = 1'b1;
            sel_idx   = N_REG_BITS'(k);
         end
      end
   end

   assign sel_take = any_match && take[sel_idx];

   // one-hot decrement; ID is wrong-path while a jump is pending, so mask it
   always_comb begin
      hwlp_dec_cnt_o = '0;
      if (rst_n && (state == HWLP_IDLE) && any_match) begin
         hwlp_dec_cnt_o[sel_idx] = 1'b1;
      end
   end

   // jump request FSM with registered valid and target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HWLP_IDLE;
         hwlp_jump_o   <= 1'b0;
         hwlp_target_o <= 32'd0;
      end else begin
         case (state)
            HWLP_IDLE: begin
               if (sel_take && id_advance_i && !flush_i) begin
                  state         <= HWLP_JUMP_PEND;
                  hwlp_jump_o   <= 1'b1;
                  hwlp_target_o <= hwlp_start_addr_i[sel_idx];
               end
            end
            HWLP_JUMP_PEND: begin
               if (hwlp_jump_ready_i || flush_i) begin
                  state       <= HWLP_IDLE;
                  hwlp_jump_o <= 1'b0;
               end
            end
            default: begin
               state       <= HWLP_IDLE;
               hwlp_jump_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
